// File: rtl/lc3b_types.sv
// Shared type definitions for the lc3b codebase.
// Holds the performance-counter mode encoding and a select-width helper.
package lc3b_types;

    typedef enum logic [1:0] {
        PM_OFF   = 2'd0,
        PM_EDGE  = 2'd1,
        PM_LEVEL = 2'd2,
        PM_RUN   = 2'd3
    } perf_mode_t;

    // Width of a channel-select field; never below one bit so NCH=1 still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_channel.sv
// One performance-counter channel: configuration, run-length tracker,
// qualifying-event logic and the saturating/wrapping counter with sticky overflow.
module perf_channel
    import lc3b_types::*;
#(
    parameter int CW  = 16,
    parameter int RW  = 4,
    parameter bit SAT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trig_i,
    input  logic          enable_i,
    input  logic          clr_i,
    input  logic          cfg_load_i,
    input  perf_mode_t    cfg_mode_i,
    input  logic [RW-1:0] cfg_thresh_i,
    input  logic          cfg_cont_i,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    perf_mode_t    mode_q,   mode_d;
    logic [RW-1:0] thresh_q, thresh_d;
    logic          cont_q,   cont_d;
    logic [CW-1:0] count_q,  count_d;
    logic [RW-1:0] run_q,    run_d;
    logic          hit_q,    hit_d;
    logic          ovf_q,    ovf_d;
    logic          prev_q;

    logic at_thresh_s;
    logic qual_s;
    logic inc_s;
    logic max_s;
    logic zero_s;

    // Qualifying-event decode per mode; hit_q marks that this run already counted at threshold.
    always_comb begin
        at_thresh_s = (run_q == thresh_q);
        case (mode_q)
            PM_OFF:   qual_s = 1'b0;
            PM_EDGE:  qual_s = trig_i & ~prev_q;
            PM_LEVEL: qual_s = trig_i;
            PM_RUN:   qual_s = trig_i & at_thresh_s & (cont_q | ~hit_q);
            default:  qual_s = 1'b0;
        endcase
    end

    // Next-state for configuration, tracker and counter; clear and reconfigure both zero state.
    always_comb begin
        inc_s  = enable_i & qual_s;
        max_s  = &count_q;
        zero_s = clr_i | cfg_load_i;

        if (cfg_load_i) begin
            mode_d   = cfg_mode_i;
            thresh_d = cfg_thresh_i;
            cont_d   = cfg_cont_i;
        end else begin
            mode_d   = mode_q;
            thresh_d = thresh_q;
            cont_d   = cont_q;
        end

        if (zero_s) begin
            run_d   = '0;
            hit_d   = 1'b0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (!trig_i) begin
                run_d = '0;
            end else if (at_thresh_s) begin
                run_d = run_q;
            end else begin
                run_d = run_q + RW'(1);
            end
            hit_d = trig_i & at_thresh_s;

            if (inc_s && max_s) begin
                count_d = SAT ? count_q : '0;
                ovf_d   = 1'b1;
            end else if (inc_s) begin
                count_d = count_q + CW'(1);
                ovf_d   = ovf_q;
            end else begin
                count_d = count_q;
                ovf_d   = ovf_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= PM_OFF;
            thresh_q <= '0;
            cont_q   <= 1'b0;
            count_q  <= '0;
            run_q    <= '0;
            hit_q    <= 1'b0;
            ovf_q    <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
            cont_q   <= cont_d;
            count_q  <= count_d;
            run_q    <= run_d;
            hit_q    <= hit_d;
            ovf_q    <= ovf_d;
            prev_q   <= trig_i;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NCH independent performance counters with per-channel configuration,
// a registered readout port and sticky per-channel overflow flags.
module perf_counter_bank
    import lc3b_types::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int RW  = 4,
    parameter bit SAT = 1'b1,
    localparam int CHW = sel_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   trig,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  perf_mode_t       cfg_mode,
    input  logic [RW-1:0]    cfg_thresh,
    input  logic             cfg_cont,
    input  logic             clr,
    input  logic [CHW-1:0]   rd_ch,
    output logic [CW-1:0]    rd_data,
    output logic [NCH-1:0]   ovf
);

    logic [CW-1:0] count_s [NCH];
    logic [CW-1:0] rd_sel_s;
    logic [CW-1:0] rd_data_q, rd_data_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        perf_channel #(
            .CW  (CW),
            .RW  (RW),
            .SAT (SAT)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .trig_i       (trig[g]),
            .enable_i     (enable),
            .clr_i        (clr),
            .cfg_load_i   (cfg_we && (cfg_ch == CHW'(g))),
            .cfg_mode_i   (cfg_mode),
            .cfg_thresh_i (cfg_thresh),
            .cfg_cont_i   (cfg_cont),
            .count_o      (count_s[g]),
            .ovf_o        (ovf[g])
        );
    end

    // Readout mux; a select beyond NCH-1 reads as zero.
    always_comb begin
        rd_sel_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                rd_sel_s = count_s[i];
            end else begin
                rd_sel_s = rd_sel_s;
            end
        end
        rd_data_d = rd_sel_s;
    end

    // Readout register captures the pre-edge count of the selected channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
